// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler for a shared 8:1 mux: registered select, one-hot grant,
// per-grant cycle limit and one dead cycle between consecutive grants.
module mux8_rr_scheduler #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [3:0] HOLD_LIMIT = 4'(HOLD_MAX);

  logic [1:0] state;
  logic [2:0] ptr;
  logic [3:0] cnt;
  logic [2:0] own;

  logic       found;
  logic [2:0] pick;

  // Scan ptr, ptr+1, ... ptr+7; the 3-bit add wraps 7 -> 0 on its own.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    found = 1'b0;
    pick  = ptr;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // NOTE: all state and outputs update with non-blocking assignments so every
  // register samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 3'd0;
      cnt   <= 4'd0;
      own   <= 3'd0;
      sel   <= 3'd0;
      gnt   <= 8'h00;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (enable && found) begin
            state <= GRANT;
            own   <= pick;
            sel   <= pick;
            gnt   <= 8'b1 << pick;
            valid <= 1'b1;
            cnt   <= 4'd1;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          // Owner release, hold limit and disable all end the grant the same way.
          if (!req[own] || cnt == HOLD_LIMIT || !enable) begin
            state <= GAP;
            gnt   <= 8'h00;
            valid <= 1'b0;
            ptr   <= own + 3'd1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 8'h00;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Bench for mux8_rr_scheduler: fixed vector table, corner-case sequences and
// random traffic against a behavioural model, on two hold limits (4 and 1).
module tb_mux8_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] req = 8'h00;

  logic [2:0] sel_a, sel_b;
  logic [7:0] gnt_a, gnt_b;
  logic       valid_a, valid_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux8_rr_scheduler #(.HOLD_MAX(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
    .sel(sel_a), .gnt(gnt_a), .valid(valid_a)
  );

  mux8_rr_scheduler #(.HOLD_MAX(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
    .sel(sel_b), .gnt(gnt_b), .valid(valid_b)
  );

  // Model: who owns the mux (-1 = nobody), how long, and who is scanned first.
  int hold_of [2] = '{4, 1};
  int m_own   [2];
  int m_len   [2];
  int m_first [2];
  int m_sel   [2];

  typedef struct {
    logic [7:0] req;
    logic       en;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_own[d] = -1;
      m_len[d] = 0;
      m_first[d] = 0;
      m_sel[d] = 0;
    end
  endtask

  task automatic model_step(input logic [7:0] r, input logic e);
    for (int d = 0; d < 2; d++) begin
      if (m_own[d] >= 0) begin
        if (!r[m_own[d]] || m_len[d] == hold_of[d] || !e) begin
          m_first[d] = (m_own[d] + 1) % 8;
          m_own[d] = -1;
        end else begin
          m_len[d]++;
        end
      end else if (e && r != 8'h00) begin
        for (int j = 0; j < 8; j++) begin
          int k;
          k = (m_first[d] + j) % 8;
          if (m_own[d] < 0 && r[k]) begin
            m_own[d] = k;
            m_sel[d] = k;
            m_len[d] = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [7:0] model_gnt(input int d);
    return (m_own[d] >= 0) ? (8'h01 << m_own[d]) : 8'h00;
  endfunction

  task automatic compare_model();
    check("model_gnt_a",   gnt_a,   model_gnt(0));
    check("model_sel_a",   sel_a,   m_sel[0]);
    check("model_valid_a", valid_a, m_own[0] >= 0);
    check("model_gnt_b",   gnt_b,   model_gnt(1));
    check("model_sel_b",   sel_b,   m_sel[1]);
    check("model_valid_b", valid_b, m_own[1] >= 0);
  endtask

  // Called at a falling edge: drive, let the rising edge pass, then compare.
  task automatic cycle(input logic [7:0] r, input logic e);
    req = r;
    enable = e;
    @(posedge clk);
    model_step(r, e);
    #1;
    compare_model();
    @(negedge clk);
  endtask

  // Asynchronous reset between edges; outputs must clear with no clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_gnt_a"},   gnt_a,   8'h00);
    check({tag, "_rst_valid_a"}, valid_a, 1'b0);
    check({tag, "_rst_sel_a"},   sel_a,   3'd0);
    check({tag, "_rst_gnt_b"},   gnt_b,   8'h00);
    check({tag, "_rst_valid_b"}, valid_b, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // HOLD_MAX=4 from reset: hold limit, early release, wrap, enable drop.
    tbl[0]  = '{8'h20, 1'b1, 8'h20, 3'd5, 1'b1};
    tbl[1]  = '{8'h20, 1'b1, 8'h20, 3'd5, 1'b1};
    tbl[2]  = '{8'h20, 1'b1, 8'h20, 3'd5, 1'b1};
    tbl[3]  = '{8'h20, 1'b1, 8'h20, 3'd5, 1'b1};
    tbl[4]  = '{8'h20, 1'b1, 8'h00, 3'd5, 1'b0};
    tbl[5]  = '{8'h20, 1'b1, 8'h20, 3'd5, 1'b1};
    tbl[6]  = '{8'h08, 1'b1, 8'h00, 3'd5, 1'b0};
    tbl[7]  = '{8'h08, 1'b1, 8'h08, 3'd3, 1'b1};
    tbl[8]  = '{8'h08, 1'b1, 8'h08, 3'd3, 1'b1};
    tbl[9]  = '{8'h00, 1'b1, 8'h00, 3'd3, 1'b0};
    tbl[10] = '{8'h00, 1'b1, 8'h00, 3'd3, 1'b0};
    tbl[11] = '{8'h05, 1'b1, 8'h01, 3'd0, 1'b1};
    tbl[12] = '{8'h04, 1'b1, 8'h00, 3'd0, 1'b0};
    tbl[13] = '{8'h04, 1'b1, 8'h04, 3'd2, 1'b1};
    tbl[14] = '{8'h04, 1'b0, 8'h00, 3'd2, 1'b0};
    tbl[15] = '{8'h04, 1'b0, 8'h00, 3'd2, 1'b0};
    tbl[16] = '{8'h04, 1'b0, 8'h00, 3'd2, 1'b0};
    tbl[17] = '{8'h04, 1'b1, 8'h04, 3'd2, 1'b1};

    model_reset();
    #1;
    rst_n = 1'b0;
    #2;
    check("init_gnt_a",   gnt_a,   8'h00);
    check("init_valid_a", valid_a, 1'b0);
    check("init_sel_a",   sel_a,   3'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].req, tbl[i].en);
      check($sformatf("tbl%0d_gnt", i),   gnt_a,   tbl[i].gnt);
      check($sformatf("tbl%0d_sel", i),   sel_a,   tbl[i].sel);
      check($sformatf("tbl%0d_valid", i), valid_a, tbl[i].valid);
    end

    // Reset in the middle of a grant with every requester active.
    cycle(8'hFF, 1'b1);
    check("pre_rst_valid_a", valid_a, 1'b1);
    async_reset("midgrant");

    // Full rotation: four cycles per requester, one gap each, back to 0.
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 4; c++) begin
        cycle(8'hFF, 1'b1);
        check($sformatf("rot%0d_gnt", k), gnt_a, 8'h01 << (k % 8));
        check($sformatf("rot%0d_sel", k), sel_a, k % 8);
      end
      cycle(8'hFF, 1'b1);
      check($sformatf("rot%0d_gap", k), valid_a, 1'b0);
    end

    // Enable dropped during the third grant cycle of requester 4.
    async_reset("endrop");
    for (int c = 0; c < 3; c++) begin
      cycle(8'h10, 1'b1);
      check("en_grant_gnt", gnt_a, 8'h10);
    end
    cycle(8'h10, 1'b0);
    check("en_drop_gnt", gnt_a, 8'h00);
    for (int c = 0; c < 3; c++) begin
      cycle(8'h10, 1'b0);
      check("en_low_gnt", gnt_a, 8'h00);
    end
    cycle(8'h10, 1'b1);
    check("en_resume_gnt", gnt_a, 8'h10);
    check("en_resume_sel", sel_a, 3'd4);

    // Random traffic against the model, enable mostly high.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      logic       e;
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
      e = ($urandom_range(0, 9) != 0);
      cycle(r, e);
      check("onehot_a", $onehot0(gnt_a), 1'b1);
      check("onehot_b", $onehot0(gnt_b), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
